// File: rtl/imm_decomposer_if.sv
// imm_decomposer_if: handshake bundle between a value producer, the
// immediate decomposer and the word consumer.
//   in_valid/in_ready/in_value/in_kind : value input handshake
//   out_valid/out_ready/out_zors/out_imm/out_last/out_err : word output handshake
//   split_count : saturating count of values that needed two words
// The slave modport is the decomposer; master is the surrounding logic.
interface imm_decomposer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        in_kind;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  out_zors;
    logic [15:0] out_imm;
    logic        out_last;
    logic        out_err;
    logic [7:0]  split_count;

    modport slave (
        input  in_valid, in_value, in_kind, out_ready,
        output in_ready, out_valid, out_zors, out_imm, out_last, out_err, split_count
    );

    modport master (
        output in_valid, in_value, in_kind, out_ready,
        input  in_ready, out_valid, out_zors, out_imm, out_last, out_err, split_count
    );
endinterface

// File: rtl/imm_decomposer.sv
// imm_decomposer: splits a 32-bit data constant or branch byte offset into one
// or two (zors, imm16) words that the immediate extender rebuilds exactly.
//   clk   : clock, rising edge
//   reset : synchronous, active-high
//   bus   : imm_decomposer_if.slave (value in, words out, split_count)
// Zors modes: 00 sign-ext, 01 zero-ext, 10 upper-half, 11 zero-ext << 2.
// Words are decoded purely from the registered value/kind and state, so
// there is no combinational path from the input side to the output side.
module imm_decomposer (
    input  logic              clk,
    input  logic              reset,
    imm_decomposer_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, EMIT1, EMIT2} state_t;

    state_t      state, state_nxt;
    logic [31:0] val_q;
    logic        kind_q;
    logic [7:0]  split_q;

    logic        accept;
    logic [1:0]  zors;
    logic [15:0] imm;
    logic        last;
    logic        err;

    // A data constant needs two words only when none of the single-word
    // forms (sign-ext, zero-ext, upper-half) can express it.
    function automatic logic needs_split(input logic [31:0] v);
        logic sext_ok;
        sext_ok = (&v[31:15]) | ~(|v[31:15]);
        return !sext_ok && (v[31:16] != 16'h0) && (v[15:0] != 16'h0);
    endfunction

    assign accept = bus.in_valid && (state == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            val_q   <= 32'h0;
            kind_q  <= 1'b0;
            split_q <= 8'h0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                val_q  <= bus.in_value;
                kind_q <= bus.in_kind;
                if (!bus.in_kind && needs_split(bus.in_value) && split_q != 8'hFF)
                    split_q <= split_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        zors      = 2'b00;
        imm       = 16'h0;
        last      = 1'b0;
        err       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) state_nxt = EMIT1;
            end
            EMIT1: begin
                if (kind_q) begin
                    zors = 2'b11;
                    last = 1'b1;
                    if (val_q[1:0] == 2'b00 && val_q[31:18] == 14'h0)
                        imm = val_q[17:2];
                    else
                        err = 1'b1;
                end else if ((&val_q[31:15]) | ~(|val_q[31:15])) begin
                    zors = 2'b00;
                    imm  = val_q[15:0];
                    last = 1'b1;
                end else if (val_q[31:16] == 16'h0) begin
                    zors = 2'b01;
                    imm  = val_q[15:0];
                    last = 1'b1;
                end else begin
                    // Upper half first; last stays low if a low half remains.
                    zors = 2'b10;
                    imm  = val_q[31:16];
                    last = (val_q[15:0] == 16'h0);
                end
                if (bus.out_ready) state_nxt = last ? IDLE : EMIT2;
            end
            EMIT2: begin
                zors = 2'b01;
                imm  = val_q[15:0];
                last = 1'b1;
                if (bus.out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state != IDLE);
    assign bus.out_zors    = zors;
    assign bus.out_imm     = imm;
    assign bus.out_last    = last;
    assign bus.out_err     = err;
    assign bus.split_count = split_q;
endmodule

// File: tb/tb_imm_decomposer.sv
module tb_imm_decomposer;
    logic clk = 1'b0;
    logic reset;

    imm_decomposer_if bus ();

    imm_decomposer dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  zors;
        logic [15:0] imm;
        logic        last;
        logic        err;
    } word_t;

    typedef struct {
        int    n;
        word_t w0;
        word_t w1;
    } exp_t;

    typedef struct {
        logic        kind;
        logic [31:0] value;
        logic [1:0]  zors;
        logic [15:0] imm;
        logic        err;
    } vec_t;

    int tests = 0;
    int fails = 0;
    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: choose the encoding from value ranges, not bit slicing.
    function automatic exp_t model(input logic kind, input logic [31:0] v);
        exp_t e;
        longint sv;
        e.n  = 1;
        e.w0 = '{2'b00, 16'h0, 1'b1, 1'b0};
        e.w1 = '{2'b00, 16'h0, 1'b1, 1'b0};
        sv = longint'($signed(v));
        if (kind) begin
            if (v % 4 == 0 && v < 32'h40000) e.w0 = '{2'b11, 16'(v / 4), 1'b1, 1'b0};
            else                             e.w0 = '{2'b11, 16'h0, 1'b1, 1'b1};
        end else if (sv >= -32768 && sv <= 32767) begin
            e.w0 = '{2'b00, 16'(v % 65536), 1'b1, 1'b0};
        end else if (v < 65536) begin
            e.w0 = '{2'b01, 16'(v), 1'b1, 1'b0};
        end else if (v % 65536 == 0) begin
            e.w0 = '{2'b10, 16'(v / 65536), 1'b1, 1'b0};
        end else begin
            e.n  = 2;
            e.w0 = '{2'b10, 16'(v / 65536), 1'b0, 1'b0};
            e.w1 = '{2'b01, 16'(v % 65536), 1'b1, 1'b0};
        end
        return e;
    endfunction

    // Extender model: what the datapath rebuilds from one word.
    function automatic logic [31:0] ext(input logic [1:0] z, input logic [15:0] i);
        case (z)
            2'b00:   return 32'($signed(i));
            2'b01:   return {16'h0, i};
            2'b10:   return {i, 16'h0};
            default: return {14'h0, i, 2'b00};
        endcase
    endfunction

    task automatic send(input logic k, input logic [31:0] v);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!bus.in_ready) check("send_timeout", 32'd0, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_kind  = k;
        bus.in_value = v;
        tick();
        bus.in_valid = 1'b0;
        bus.in_kind  = 1'($urandom);
        bus.in_value = $urandom;
    endtask

    // Wait for one word and take it; with rnd set, out_ready toggles randomly
    // and the word must stay stable across any stall.
    task automatic recv(input bit rnd, output word_t w, output bit held_ok);
        word_t cur, got;
        bit have = 0, done = 0;
        int n = 0;
        held_ok = 1;
        got = '{2'b00, 16'h0, 1'b0, 1'b0};
        while (!done && n < 100) begin
            bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.out_valid) begin
                cur = '{bus.out_zors, bus.out_imm, bus.out_last, bus.out_err};
                if (have && cur != got) held_ok = 0;
                got  = cur;
                have = 1;
                if (bus.out_ready) done = 1;
            end
            tick();
            n++;
        end
        if (!done) check("recv_timeout", 32'd0, 32'd1);
        bus.out_ready = 1'b1;
        w = got;
    endtask

    task automatic check_word(input string tag, input word_t a, input word_t e);
        check({tag, "_zors"}, 32'(a.zors), 32'(e.zors));
        check({tag, "_imm"},  32'(a.imm),  32'(e.imm));
        check({tag, "_last"}, 32'(a.last), 32'(e.last));
        check({tag, "_err"},  32'(a.err),  32'(e.err));
    endtask

    // Full model-checked transaction; returns the rebuilt value.
    task automatic run_one(input logic k, input logic [31:0] v, input bit rnd,
                           output logic [31:0] recon, output int nw);
        exp_t  e;
        word_t w;
        bit    ok;
        e = model(k, v);
        send(k, v);
        recv(rnd, w, ok);
        check_word("rnd_w0", w, e.w0);
        check("rnd_hold0", 32'(ok), 32'd1);
        recon = ext(w.zors, w.imm);
        if (e.n == 2) begin
            recv(rnd, w, ok);
            check_word("rnd_w1", w, e.w1);
            check("rnd_hold1", 32'(ok), 32'd1);
            recon = recon | ext(w.zors, w.imm);
        end
        nw = e.n;
    endtask

    initial begin
        word_t       w;
        bit          ok;
        logic [31:0] recon, v;
        int          nw, sc;

        vecs[0]  = '{1'b0, 32'hFFFF8000, 2'b00, 16'h8000, 1'b0};
        vecs[1]  = '{1'b0, 32'h0000ABCD, 2'b01, 16'hABCD, 1'b0};
        vecs[2]  = '{1'b0, 32'h12340000, 2'b10, 16'h1234, 1'b0};
        vecs[3]  = '{1'b0, 32'h00001234, 2'b00, 16'h1234, 1'b0};
        vecs[4]  = '{1'b1, 32'h0000FFFC, 2'b11, 16'h3FFF, 1'b0};
        vecs[5]  = '{1'b1, 32'h00000006, 2'b11, 16'h0000, 1'b1};
        vecs[6]  = '{1'b1, 32'h00040000, 2'b11, 16'h0000, 1'b1};
        vecs[7]  = '{1'b0, 32'h00000000, 2'b00, 16'h0000, 1'b0};
        vecs[8]  = '{1'b0, 32'h00007FFF, 2'b00, 16'h7FFF, 1'b0};
        vecs[9]  = '{1'b0, 32'h00008000, 2'b01, 16'h8000, 1'b0};
        vecs[10] = '{1'b0, 32'hFFFFFFFF, 2'b00, 16'hFFFF, 1'b0};
        vecs[11] = '{1'b1, 32'h0003FFFC, 2'b11, 16'hFFFF, 1'b0};
        vecs[12] = '{1'b1, 32'hFFFFFFFC, 2'b11, 16'h0000, 1'b1};

        reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_kind   = 1'b0;
        bus.in_value  = 32'h0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        check("rst_in_ready",  32'(bus.in_ready),    32'd1);
        check("rst_out_valid", 32'(bus.out_valid),   32'd0);
        check("rst_zors",      32'(bus.out_zors),    32'd0);
        check("rst_imm",       32'(bus.out_imm),     32'd0);
        check("rst_last",      32'(bus.out_last),    32'd0);
        check("rst_err",       32'(bus.out_err),     32'd0);
        check("rst_split",     32'(bus.split_count), 32'd0);

        // Latency and in_ready recovery for a single-word value.
        send(1'b0, 32'hFFFF8000);
        check("lat_in_ready0", 32'(bus.in_ready),  32'd0);
        check("lat_valid",     32'(bus.out_valid), 32'd1);
        check("lat_zors",      32'(bus.out_zors),  32'd0);
        check("lat_imm",       32'(bus.out_imm),   32'h8000);
        check("lat_last",      32'(bus.out_last),  32'd1);
        tick();
        check("lat_in_ready1", 32'(bus.in_ready),  32'd1);
        check("lat_valid0",    32'(bus.out_valid), 32'd0);

        for (int i = 0; i < 13; i++) begin
            send(vecs[i].kind, vecs[i].value);
            recv(1'b0, w, ok);
            check_word($sformatf("vec%0d", i), w,
                       '{vecs[i].zors, vecs[i].imm, 1'b1, vecs[i].err});
        end

        // Two-word value under backpressure.
        bus.out_ready = 1'b0;
        send(1'b0, 32'h12345678);
        for (int c = 0; c < 3; c++) begin
            check("bp_valid", 32'(bus.out_valid), 32'd1);
            check("bp_zors",  32'(bus.out_zors),  32'd2);
            check("bp_imm",   32'(bus.out_imm),   32'h1234);
            check("bp_last",  32'(bus.out_last),  32'd0);
            tick();
        end
        bus.out_ready = 1'b1;
        check("bp_zors_rel", 32'(bus.out_zors), 32'd2);
        tick();
        check("bp2_valid", 32'(bus.out_valid), 32'd1);
        check("bp2_zors",  32'(bus.out_zors),  32'd1);
        check("bp2_imm",   32'(bus.out_imm),   32'h5678);
        check("bp2_last",  32'(bus.out_last),  32'd1);
        check("bp2_err",   32'(bus.out_err),   32'd0);
        tick();
        check("bp_done_valid", 32'(bus.out_valid),   32'd0);
        check("bp_split",      32'(bus.split_count), 32'd1);

        // Reset while the second word is pending.
        send(1'b0, 32'hCAFE0001);
        recv(1'b0, w, ok);
        check("mid_in_emit2", 32'(bus.out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_valid",    32'(bus.out_valid),   32'd0);
        check("mid_in_ready", 32'(bus.in_ready),    32'd1);
        check("mid_split",    32'(bus.split_count), 32'd0);
        send(1'b0, 32'h00000001);
        recv(1'b0, w, ok);
        check_word("post_rst", w, '{2'b00, 16'h0001, 1'b1, 1'b0});

        // 300 two-word values, random stalls, saturating counter.
        sc = 0;
        for (int i = 0; i < 300; i++) begin
            v = {16'($urandom_range(1, 16'hFFFE)), 16'($urandom_range(1, 16'hFFFF))};
            run_one(1'b0, v, 1'b1, recon, nw);
            check("sat_nwords", 32'(nw), 32'd2);
            check("sat_recon", recon, v);
            sc = (sc < 255) ? sc + 1 : 255;
        end
        check("sat_split", 32'(bus.split_count), 32'(sc));

        // Mixed random values of both kinds.
        for (int i = 0; i < 200; i++) begin
            logic k;
            k = 1'($urandom);
            case ($urandom_range(0, 3))
                0:       v = $urandom;
                1:       v = 32'($signed(16'($urandom)));
                2:       v = {16'($urandom), 16'h0};
                default: v = {14'h0, 16'($urandom), 2'($urandom_range(0, 3) == 0 ? 1 : 0)};
            endcase
            run_one(k, v, 1'b1, recon, nw);
            if (!model(k, v).w0.err) check("mix_recon", recon, v);
        end
        check("mix_split", 32'(bus.split_count), 32'd255);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/imm_decomposer.md
# imm_decomposer

Decomposes a 32-bit constant or branch byte offset into one or two (ZorS mode, 16-bit immediate) words that the datapath's immediate extender reconstructs exactly. It is the encoder-side inverse of the extend stage. It sits in the code/constant generation path feeding the instruction assembler. Operation uses a valid/ready handshake: one value in, up to two words out.

## Interface
- No parameters.
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_value/in_kind presented
- in_ready  out  1  block can accept a value (IDLE only)
- in_value  in  32  constant, or branch byte offset
- in_kind  in  1  0 = data constant, 1 = branch offset
- out_valid  out  1  output word presented
- out_ready  in  1  consumer accepts output word
- out_zors  out  2  extender mode: 00 sign-ext, 01 zero-ext, 10 upper-half (LUI), 11 zero-ext shifted left 2
- out_imm  out  16  immediate field
- out_last  out  1  final word for the current value
- out_err  out  1  value not representable; word carries zors=11, imm=0, last=1
- split_count  out  8  saturating count of values that needed two words

## Operation
- States: IDLE, EMIT1, EMIT2.
- Accept occurs when in_valid && in_ready. The value and kind are registered and the state moves to EMIT1.
- Output transfer occurs when out_valid && out_ready.
- Data constant (in_kind=0): the first matching rule applies.
  - in_value[31:15] all equal: one word, zors=00, imm=in_value[15:0].
  - in_value[31:16]==0: one word, zors=01, imm=in_value[15:0].
  - in_value[15:0]==0: one word, zors=10, imm=in_value[31:16].
  - Otherwise, two words:
    - EMIT1: zors=10, imm=in_value[31:16], last=0.
    - EMIT2: zors=01, imm=in_value[15:0], last=1.
    - split_count increments on accept and saturates at 255.
- Branch offset (in_kind=1):
  - Representable iff in_value[1:0]==0 and in_value[31:18]==0. Emit one word: zors=11, imm=in_value[17:2], last=1, err=0.
  - Otherwise emit one word with err=1, zors=11, imm=0, last=1.
- State transitions:
  - EMIT1: transfer with last=1 goes to IDLE; transfer with last=0 goes to EMIT2.
  - EMIT2: transfer goes to IDLE.
- out_valid = (state != IDLE). in_ready = (state == IDLE).
- out_err is 0 on every word except the error word.

## Timing
- Reset values:
  - state IDLE; in_ready=1.
  - out_valid=0, out_zors=00, out_imm=0, out_last=0, out_err=0.
  - split_count=0.
- Latency: a value accepted at edge N has its first word valid in the cycle after edge N.
  - The second word is valid the cycle after the first word's transfer.
- Back-to-back throughput:
  - No new accept in the same cycle as the last transfer; in_ready rises the cycle after.
  - Minimum 2 cycles per single-word value, 3 per two-word value.
- Backpressure: while out_valid && !out_ready, all out_* outputs are held stable.
- in_value and in_kind are ignored when in_ready=0.
- Reset mid-operation discards pending words. The cycle after reset, out_valid=0 and in_ready=1.
- All outputs are registered or decoded from registered state. There is no combinational path from in_* to out_*.

## Test plan
- in_kind=0, in_value=0xFFFF8000, out_ready=1 -> one word: zors=00, imm=0x8000, last=1. in_ready high again 2 cycles after accept.
- in_kind=0, values 0x0000ABCD, 0x12340000, 0x00001234:
  - 0x0000ABCD -> zors=01, imm=0xABCD.
  - 0x12340000 -> zors=10, imm=0x1234.
  - 0x00001234 -> zors=00 (priority), imm=0x1234.
- in_kind=0, in_value=0x12345678, out_ready low 3 cycles then high:
  - First word zors=10, imm=0x1234, last=0, held stable.
  - Then zors=01, imm=0x5678, last=1.
  - split_count=1.
- in_kind=1, values 0x0000FFFC, 0x00000006, 0x00040000:
  - 0x0000FFFC -> zors=11, imm=0x3FFF, err=0.
  - 0x00000006 -> err=1, imm=0.
  - 0x00040000 -> err=1, imm=0.
- Reset asserted while in EMIT2 -> next cycle out_valid=0, in_ready=1, split_count=0. A subsequent 0x00000001 yields zors=00, imm=0x0001.
- 300 two-word values back-to-back -> split_count saturates at 255; a reference-model extender reconstructs every value exactly.
